// File: rtl/gpio_in_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pkg
// Purpose  : Register map and edge-select encodings for gpio_in_capture.
// Revision : 1.0
// ============================================================================
package gpio_pkg;

   typedef enum logic [1:0] {
      REG_DATA     = 2'd0,
      REG_RESERVED = 2'd1,
      REG_IRQMASK  = 2'd2,
      REG_EDGECAP  = 2'd3
   } reg_addr_e;

   localparam int c_edge_rising  = 0;
   localparam int c_edge_falling = 1;
   localparam int c_edge_any     = 2;

   function automatic logic edge_match(input int edge_type, input logic rise,
                                       input logic fall);
      case (edge_type)
         c_edge_rising:  return rise;
         c_edge_falling: return fall;
         default:        return rise | fall;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_in_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : gpio_in_capture_if
// Purpose  : Avalon-MM slave bus plus interrupt line of gpio_in_capture.
// Revision : 1.0
// ============================================================================
interface gpio_in_capture_if #(
   parameter int WIDTH = 2
) ();
   logic [1:0]       address;
   logic             chipselect;
   logic             read_n;
   logic             write_n;
   logic [WIDTH-1:0] writedata;
   logic [WIDTH-1:0] readdata;
   logic             irq;

   modport master (
      output address, chipselect, read_n, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, read_n, write_n, writedata,
      output readdata, irq
   );
endinterface
`default_nettype wire

// File: rtl/gpio_in_capture_debounce.sv
`default_nettype none
// ============================================================================
// Module   : gpio_debounce_bit
// Purpose  : Two-flop synchronizer and saturating debounce for one input pin.
// Revision : 1.0
// ============================================================================
module gpio_debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  wire logic clk,
   input  wire logic reset_n,
   input  wire logic i_pin,
   output logic      o_debounced,
   output logic      o_rise,
   output logic      o_fall
);
   localparam int                c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES);

   logic               r_sync1;
   logic               r_sync2;
   logic               r_deb;
   logic [c_cnt_w-1:0] r_cnt;
   logic               w_differ;
   logic               w_accept;

   assign w_differ = r_sync2 ^ r_deb;
   // Counter tops out at the limit; the following differing edge commits the change
   assign w_accept = w_differ && (r_cnt == c_cnt_max);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_deb   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_pin;
         r_sync2 <= r_sync1;
         if (!w_differ || w_accept) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_accept) begin
            r_deb <= r_sync2;
         end
      end
   end

   assign o_debounced = r_deb;
   assign o_rise      = w_accept &  r_sync2;
   assign o_fall      = w_accept & ~r_sync2;

endmodule
`default_nettype wire

// File: rtl/gpio_in_capture.sv
`default_nettype none
// ============================================================================
// Module   : gpio_in_capture
// Purpose  : Debounced GPIO inputs with edge capture, IRQ mask and Avalon-MM access.
// Revision : 1.0
// ============================================================================
module gpio_in_capture
   import gpio_pkg::*;
#(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_TYPE       = 0
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   input  wire logic [WIDTH-1:0] in_port,
   gpio_in_capture_if.slave      bus
);
   logic [WIDTH-1:0] w_data;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_capture;
   logic [WIDTH-1:0] w_clear;
   logic [WIDTH-1:0] w_rd_mux;
   logic             w_wr;
   logic             w_rd;
   logic [WIDTH-1:0] r_irq_mask;
   logic [WIDTH-1:0] r_edge_cap;
   logic [WIDTH-1:0] r_readdata;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bits
         gpio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_deb (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_pin      (in_port[i]),
            .o_debounced(w_data[i]),
            .o_rise     (w_rise[i]),
            .o_fall     (w_fall[i])
         );
         assign w_capture[i] = edge_match(EDGE_TYPE, w_rise[i], w_fall[i]);
      end
   endgenerate

   assign w_wr    = bus.chipselect & ~bus.write_n;
   assign w_rd    = bus.chipselect & ~bus.read_n;
   assign w_clear = (w_wr && (reg_addr_e'(bus.address) == REG_EDGECAP)) ?
                    bus.writedata : '0;

   always_comb begin
      w_rd_mux = '0;
      case (reg_addr_e'(bus.address))
         REG_DATA:    w_rd_mux = w_data;
         REG_IRQMASK: w_rd_mux = r_irq_mask;
         REG_EDGECAP: w_rd_mux = r_edge_cap;
         default:     w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_mask <= '0;
         r_edge_cap <= '0;
         r_readdata <= '0;
      end else begin
         if (w_wr && (reg_addr_e'(bus.address) == REG_IRQMASK)) begin
            r_irq_mask <= bus.writedata;
         end
         // A fresh capture overrides a clear landing on the same edge
         r_edge_cap <= (r_edge_cap & ~w_clear) | w_capture;
         if (w_rd) begin
            r_readdata <= w_rd_mux;
         end
      end
   end

   assign bus.readdata = r_readdata;
   assign bus.irq      = |(r_edge_cap & r_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_gpio_in_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_in_capture
// Purpose  : Directed self-checking bench for gpio_in_capture.
// Revision : 1.0
// ============================================================================
module tb_gpio_in_capture;
   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] in_port0;
   logic [1:0] in_port1;
   logic [1:0] d;
   int         checks   = 0;
   int         failures = 0;
   logic [1:0] rst_addrs [8] = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

   always #5 clk = ~clk;

   gpio_in_capture_if #(.WIDTH(2)) bus0 ();
   gpio_in_capture_if #(.WIDTH(2)) bus1 ();

   gpio_in_capture #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .in_port(in_port0), .bus(bus0.slave));

   gpio_in_capture #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_port(in_port1), .bus(bus1.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus0.chipselect = 1'b0; bus0.read_n = 1'b1; bus0.write_n = 1'b1;
      bus1.chipselect = 1'b0; bus1.read_n = 1'b1; bus1.write_n = 1'b1;
   endtask

   task automatic wr0(input logic [1:0] a, input logic [1:0] v);
      bus0.address = a; bus0.writedata = v; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
      tick();
      idle();
   endtask

   task automatic rd(input int sel, input logic [1:0] a, output logic [1:0] v);
      if (sel == 0) begin
         bus0.address = a; bus0.chipselect = 1'b1; bus0.read_n = 1'b0;
      end else begin
         bus1.address = a; bus1.chipselect = 1'b1; bus1.read_n = 1'b0;
      end
      tick();
      idle();
      v = (sel == 0) ? bus0.readdata : bus1.readdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n  = 1'b0;
      in_port0 = 2'b00;
      in_port1 = 2'b00;
      bus0.address = 2'd0; bus0.writedata = 2'b00;
      bus1.address = 2'd0; bus1.writedata = 2'b00;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("reset_readdata", 32'(bus0.readdata), 32'h0);
      check("reset_irq", 32'(bus0.irq), 32'h0);
      reset_n = 1'b1;
      tick();

      for (int a = 0; a < 4; a++) begin
         rd(0, 2'(a), d);
         check($sformatf("post_reset_reg%0d", a), 32'(d), 32'h0);
      end

      wr0(2'd2, 2'b01);
      rd(0, 2'd2, d);  check("irqmask_rw", 32'(d), 32'h1);
      wr0(2'd1, 2'b11);
      rd(0, 2'd1, d);  check("reserved_reads_zero", 32'(d), 32'h0);
      wr0(2'd0, 2'b11);
      rd(0, 2'd0, d);  check("data_read_only", 32'(d), 32'h0);

      // Rising edge on bit 0: commit and capture on edge 6, seen in readdata from edge 7
      bus0.address = 2'd0; bus0.chipselect = 1'b1; bus0.read_n = 1'b0;
      in_port0 = 2'b01;
      for (int e = 0; e < 8; e++) begin
         tick();
         check($sformatf("latency_irq_e%0d", e), 32'(bus0.irq), 32'(e >= 6));
         check($sformatf("latency_data_e%0d", e), 32'(bus0.readdata), (e >= 7) ? 32'h1 : 32'h0);
      end
      idle();
      rd(0, 2'd3, d);  check("edgecap_set", 32'(d), 32'h1);
      wr0(2'd3, 2'b01);
      check("irq_after_clear", 32'(bus0.irq), 32'h0);
      rd(0, 2'd3, d);  check("edgecap_cleared", 32'(d), 32'h0);

      // Three-cycle glitch on bit 1 must be rejected
      wr0(2'd2, 2'b11);
      in_port0 = 2'b11;
      repeat (3) tick();
      in_port0 = 2'b01;
      for (int e = 0; e < 12; e++) begin
         tick();
         check($sformatf("glitch_irq_c%0d", e), 32'(bus0.irq), 32'h0);
      end
      rd(0, 2'd0, d);  check("glitch_data", 32'(d), 32'h1);
      rd(0, 2'd3, d);  check("glitch_edgecap", 32'(d), 32'h0);

      // Falling edge is ignored by a rising-edge instance
      in_port0 = 2'b00;
      repeat (10) tick();
      rd(0, 2'd0, d);  check("fall_data", 32'(d), 32'h0);
      rd(0, 2'd3, d);  check("fall_not_captured", 32'(d), 32'h0);

      // Clear lands on the same edge as a new capture
      in_port0 = 2'b01;
      repeat (6) tick();
      bus0.address = 2'd3; bus0.writedata = 2'b01; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
      tick();
      idle();
      check("set_wins_irq", 32'(bus0.irq), 32'h1);

      // Read and clear together returns the pre-clear value
      bus0.address = 2'd3; bus0.writedata = 2'b01; bus0.chipselect = 1'b1;
      bus0.write_n = 1'b0; bus0.read_n = 1'b0;
      tick();
      idle();
      check("read_preclear", 32'(bus0.readdata), 32'h1);
      check("irq_after_rw_clear", 32'(bus0.irq), 32'h0);
      rd(0, 2'd3, d);  check("edgecap_after_rw", 32'(d), 32'h0);
      rd(0, 2'd2, d);  check("irqmask_before_reset", 32'(d), 32'h3);

      // Reset in the middle of a bit-1 debounce count
      in_port0 = 2'b11;
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      check("async_reset_readdata", 32'(bus0.readdata), 32'h0);
      check("async_reset_irq", 32'(bus0.irq), 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      bus0.chipselect = 1'b1; bus0.read_n = 1'b0;
      for (int e = 0; e < 8; e++) begin
         bus0.address = rst_addrs[e];
         tick();
         check($sformatf("rst_release_rd_e%0d", e), 32'(bus0.readdata), (e >= 7) ? 32'h3 : 32'h0);
         check($sformatf("rst_release_irq_e%0d", e), 32'(bus0.irq), 32'h0);
      end
      idle();
      rd(0, 2'd3, d);  check("rst_release_edgecap", 32'(d), 32'h3);
      rd(0, 2'd2, d);  check("rst_release_irqmask", 32'(d), 32'h0);

      // Falling-edge instance: only the 1->0 transition is captured
      in_port1 = 2'b01;
      repeat (12) tick();
      rd(1, 2'd0, d);  check("fall_inst_data_high", 32'(d), 32'h1);
      rd(1, 2'd3, d);  check("fall_inst_no_rise", 32'(d), 32'h0);
      in_port1 = 2'b00;
      repeat (12) tick();
      rd(1, 2'd0, d);  check("fall_inst_data_low", 32'(d), 32'h0);
      rd(1, 2'd3, d);  check("fall_inst_captured", 32'(d), 32'h1);
      check("fall_inst_irq_masked", 32'(bus1.irq), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gpio_in_capture.md
GPIO_IN_CAPTURE -- requirements
Module: gpio_in_capture

Interface
REQ-001 Parameter WIDTH, default 2: number of input pins (1..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable clocks required before a pin change is accepted (1..65535).
REQ-003 Parameter EDGE_TYPE, default 0: 0 rising, 1 falling, 2 any edge.
REQ-004 clk  input  1  system clock; all logic is on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  2  Avalon-MM slave word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 read_n  input  1  active-low read strobe.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  WIDTH  write data.
REQ-011 in_port  input  WIDTH  asynchronous external pins.
REQ-012 readdata  output  WIDTH  read data, valid one cycle after the read strobe.
REQ-013 irq  output  1  level interrupt, active-high.

Function
REQ-014 The register map SHALL be: 0 = DATA (RO, debounced pin value); 1 = reserved (reads 0, writes ignored); 2 = IRQMASK (RW); 3 = EDGECAPTURE (read; write-1-to-clear).
REQ-015 Each in_port bit SHALL pass through a two-flop synchronizer before any other use.
REQ-016 Each bit SHALL have its own debounce counter; the counter clears on any clock where the synchronized value equals the debounced value.
REQ-017 The debounced bit SHALL take the synchronized value on the DEBOUNCE_CYCLES-th consecutive clock edge at which they differ; a glitch shorter than this never alters the debounced bit.
REQ-018 Latency: a clean pin change set up before edge 0 SHALL appear in the debounced bit after edge DEBOUNCE_CYCLES+2.
REQ-019 An EDGECAPTURE bit SHALL set on the same edge that its debounced bit updates, when the direction matches EDGE_TYPE; it stays set until cleared.
REQ-020 A write to address 3 SHALL clear each EDGECAPTURE bit whose writedata bit is 1; bits written with 0 are unchanged.
REQ-021 A capture event and a clear on the same bit in the same cycle SHALL leave that bit set (set wins).
REQ-022 A write to address 2 SHALL load IRQMASK from writedata on that edge.
REQ-023 irq SHALL be combinational: the OR of (EDGECAPTURE AND IRQMASK).
REQ-024 A read (chipselect=1, read_n=0) SHALL register the selected word into readdata at that edge; readdata holds its value until the next read.
REQ-025 A simultaneous read and write to address 3 SHALL return the pre-clear value.
REQ-026 The debounce counter SHALL saturate at DEBOUNCE_CYCLES and never wrap.
REQ-027 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1).

Reset
REQ-028 While reset_n=0: synchronizer flops, debounced bits, counters, EDGECAPTURE, IRQMASK and readdata SHALL be 0; irq SHALL be 0.
REQ-029 Reset assertion mid-debounce SHALL abort the count; after release the debounce restarts from zero against a debounced value of 0.
REQ-030 A pin held high through reset release SHALL register as a rising edge once debounced; this is intended behaviour.

Structure
REQ-031 The register address constants and the EDGE_TYPE encodings SHALL live in the shared package gpio_pkg.
REQ-032 The per-bit synchronizer plus debounce logic SHALL be one sub-module, gpio_debounce_bit, instantiated WIDTH times; the top level holds the registers, the read mux and irq.

Verification
REQ-033 DEBOUNCE_CYCLES=4, in_port[0] 0->1 before edge 0 -> DATA[0]=1 after edge 6, EDGECAPTURE[0]=1 after edge 6, never earlier.
REQ-034 3-cycle high pulse on in_port[1], DEBOUNCE_CYCLES=4 -> DATA and EDGECAPTURE stay 0, irq stays 0.
REQ-035 IRQMASK=2'b01, rising edge on bit 0 -> irq=1 in the same cycle EDGECAPTURE[0] sets; write 2'b01 to address 3 -> irq=0 next cycle.
REQ-036 Clear write to address 3 coincident with a new capture on bit 0 -> EDGECAPTURE[0] remains 1.
REQ-037 EDGE_TYPE=1, pin 0->1->0 with each level held well over the debounce time -> capture only on the 1->0 transition.
REQ-038 Assert reset_n=0 for 1 cycle mid-count with in_port=2'b11 -> all registers read 0; after release DATA=2'b11 after DEBOUNCE_CYCLES+2 edges.
